// File: rtl/module_knob_emulator_if.sv
// Step requests in; quadrature channel pair, busy, pending count and
// overflow status out.
interface module_knob_emulator_if #(
  parameter int CNT_W = 4
);
  logic                    pulse;
  logic                    direction;
  logic                    enable;
  logic                    rot_A;
  logic                    rot_B;
  logic                    busy;
  logic signed [CNT_W-1:0] pending;
  logic                    overflow;

  modport master (
    output pulse, direction, enable,
    input  rot_A, rot_B, busy, pending, overflow
  );

  modport slave (
    input  pulse, direction, enable,
    output rot_A, rot_B, busy, pending, overflow
  );
endinterface

// File: rtl/module_knob_emulator.sv
// Quadrature rotary-encoder transmitter: turns buffered step requests into
// full four-phase detent cycles on rot_A/rot_B.
module module_knob_emulator #(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input  logic                  qzt_clk,
  input  logic                  rst_n,
  module_knob_emulator_if.slave kif
);

  localparam int unsigned MAX_I = (32'd1 << (CNT_W - 32'sd1)) - 32'd1;
  localparam logic signed [CNT_W+1:0] MAX_S     = MAX_I[CNT_W+1:0];
  localparam logic signed [CNT_W+1:0] MIN_S     = -MAX_S;
  localparam logic signed [CNT_W+1:0] ONE_S     = {{(CNT_W+1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W+1:0] NEG_ONE_S = {(CNT_W+2){1'b1}};
  localparam logic signed [CNT_W+1:0] ZERO_S    = {(CNT_W+2){1'b0}};
  localparam logic [15:0]             PH_LAST   = 16'(PHASE_CYCLES - 32'sd1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    PH4  = 3'd4
  } state_t;

  state_t                  state_r;
  logic [15:0]             timer_r;
  logic                    dir_r;
  logic [1:0]              ab_r;
  logic                    busy_r;
  logic signed [CNT_W-1:0] pending_r;
  logic                    overflow_r;

  logic                    timer_done_s;
  logic                    consume_s;
  logic                    ovf_s;
  logic signed [CNT_W+1:0] req_delta_s;
  logic signed [CNT_W+1:0] cons_delta_s;
  logic signed [CNT_W+1:0] pend_ext_s;
  logic signed [CNT_W+1:0] pend_next_s;

  // A,B pattern for a phase; dir=1 swaps the roles of the two channels
  function automatic logic [1:0] phase_pattern(input state_t st, input logic dir);
    case (st)
      PH1:     phase_pattern = dir ? 2'b01 : 2'b10;
      PH2:     phase_pattern = 2'b11;
      PH3:     phase_pattern = dir ? 2'b10 : 2'b01;
      default: phase_pattern = 2'b00;
    endcase
  endfunction

  // Request/consume arithmetic; saturation is judged on the combined result
  always_comb begin
    timer_done_s = (timer_r == 16'd0);
    consume_s    = kif.enable && (pending_r != '0) &&
                   ((state_r == IDLE) || ((state_r == PH4) && timer_done_s));
    if (kif.pulse) begin
      req_delta_s = kif.direction ? NEG_ONE_S : ONE_S;
    end else begin
      req_delta_s = ZERO_S;
    end
    if (consume_s) begin
      cons_delta_s = pending_r[CNT_W-1] ? NEG_ONE_S : ONE_S;
    end else begin
      cons_delta_s = ZERO_S;
    end
    pend_ext_s  = {{2{pending_r[CNT_W-1]}}, pending_r};
    pend_next_s = pend_ext_s + req_delta_s - cons_delta_s;
    ovf_s       = (pend_next_s > MAX_S) || (pend_next_s < MIN_S);
  end

  // Pending-step counter and one-cycle overflow flag
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= '0;
      overflow_r <= 1'b0;
    end else if (ovf_s) begin
      overflow_r <= 1'b1;
    end else begin
      pending_r  <= pend_next_s[CNT_W-1:0];
      overflow_r <= 1'b0;
    end
  end

  // Phase sequencer with registered channel outputs and busy flag
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      timer_r <= 16'd0;
      dir_r   <= 1'b0;
      ab_r    <= 2'b00;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (consume_s) begin
            state_r <= PH1;
            dir_r   <= pending_r[CNT_W-1];
            timer_r <= PH_LAST;
            ab_r    <= phase_pattern(PH1, pending_r[CNT_W-1]);
            busy_r  <= 1'b1;
          end
        end
        PH1, PH2, PH3: begin
          if (timer_done_s) begin
            state_r <= state_t'(state_r + 3'd1);
            timer_r <= PH_LAST;
            ab_r    <= phase_pattern(state_t'(state_r + 3'd1), dir_r);
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        PH4: begin
          if (!timer_done_s) begin
            timer_r <= timer_r - 16'd1;
          end else if (consume_s) begin
            // Chain straight into the next detent with no idle gap
            state_r <= PH1;
            dir_r   <= pending_r[CNT_W-1];
            timer_r <= PH_LAST;
            ab_r    <= phase_pattern(PH1, pending_r[CNT_W-1]);
          end else begin
            state_r <= IDLE;
            ab_r    <= 2'b00;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= 16'd0;
          ab_r    <= 2'b00;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign kif.rot_A    = ab_r[1];
  assign kif.rot_B    = ab_r[0];
  assign kif.busy     = busy_r;
  assign kif.pending  = pending_r;
  assign kif.overflow = overflow_r;

endmodule
